// File: rtl/vu_meter_pkg.sv
// Shared constants and the log-segment level function for the VU meter.
// Each display segment covers STEP bits of sample magnitude, so level grows
// with the position of the magnitude's leading one.
package vu_meter_pkg;

    localparam int DEF_SAMPLE_W      = 24;
    localparam int DEF_N_LEDS        = 8;
    localparam int DEF_STEP          = 3;
    localparam int DEF_CHANNELS      = 2;
    localparam int DEF_HOLD_SAMPLES  = 16;
    localparam int DEF_DECAY_SAMPLES = 4;

    // Level of a non-negative magnitude: 0 for silence, otherwise the
    // leading-one position divided into STEP-bit segments, clamped to n_leds.
    function automatic int vu_level(input logic [63:0] mag, input int step, input int n_leds);
        int msb;
        int lvl;
        msb = 0;
        for (int i = 0; i < 64; i++) begin
            if (mag[i]) msb = i;
        end
        if (mag == 64'd0) begin
            lvl = 0;
        end else begin
            lvl = msb / step + 1;
            if (lvl > n_leds) lvl = n_leds;
        end
        return lvl;
    endfunction

endpackage

// File: rtl/vu_meter_if.sv
// Per-channel link between the meter top and one vu_channel.
// Handshake: sample_valid is a one-cycle strobe with no back-pressure (no
// ready); the channel accepts every strobed sample on the edge that sees it.
// bar, peak and clip are registered channel state, meaningful every cycle.
interface vu_meter_if #(
    parameter int SAMPLE_W = vu_meter_pkg::DEF_SAMPLE_W,
    parameter int LVL_W    = 4
);
    logic                sample_valid;
    logic [SAMPLE_W-1:0] sample;
    logic                clip_clear;
    logic [LVL_W-1:0]    bar;
    logic [LVL_W-1:0]    peak;
    logic                clip;

    modport master (
        output sample_valid, sample, clip_clear,
        input  bar, peak, clip
    );

    modport slave (
        input  sample_valid, sample, clip_clear,
        output bar, peak, clip
    );
endinterface

// File: rtl/vu_channel.sv
// One metered channel: magnitude, level, bar attack/decay, peak hold and
// sticky clip flag. Stage 1 registers the level; stage 2 updates bar/peak.
module vu_channel
    import vu_meter_pkg::*;
#(
    parameter int SAMPLE_W      = DEF_SAMPLE_W,
    parameter int N_LEDS        = DEF_N_LEDS,
    parameter int STEP          = DEF_STEP,
    parameter int HOLD_SAMPLES  = DEF_HOLD_SAMPLES,
    parameter int DECAY_SAMPLES = DEF_DECAY_SAMPLES,
    parameter int LVL_W         = $clog2(N_LEDS + 1)
) (
    input  logic       clock,
    input  logic       resetn,
    vu_meter_if.slave  bus
);

    localparam int HOLD_W = (HOLD_SAMPLES > 0) ? $clog2(HOLD_SAMPLES + 1) : 1;
    localparam int DCNT_W = (DECAY_SAMPLES > 1) ? $clog2(DECAY_SAMPLES) : 1;

    localparam logic [SAMPLE_W-1:0] MAG_MAX   = {1'b0, {(SAMPLE_W-1){1'b1}}};
    localparam logic [SAMPLE_W-1:0] MOST_NEG  = {1'b1, {(SAMPLE_W-1){1'b0}}};
    localparam logic [HOLD_W-1:0]   HOLD_LOAD = HOLD_W'(HOLD_SAMPLES);
    localparam logic [HOLD_W-1:0]   HOLD_ONE  = HOLD_W'(1);
    localparam logic [DCNT_W-1:0]   DCNT_LAST = DCNT_W'(DECAY_SAMPLES - 1);
    localparam logic [DCNT_W-1:0]   DCNT_ONE  = DCNT_W'(1);
    localparam logic [LVL_W-1:0]    LVL_ONE   = LVL_W'(1);

    logic [SAMPLE_W-1:0] mag;
    logic [LVL_W-1:0]    level_in;
    logic                full_scale;

    logic                v1_q;
    logic [LVL_W-1:0]    lvl_q;
    logic                clip_q;

    logic [LVL_W-1:0]    bar_q, bar_n;
    logic [LVL_W-1:0]    peak_q, peak_n, peak_dec;
    logic [HOLD_W-1:0]   hold_q, hold_n;
    logic [DCNT_W-1:0]   dcnt_q, dcnt_n;
    logic                attack;
    logic                decay_tick;

    // Magnitude with the most negative code saturated to the positive maximum.
    always_comb begin
        mag = bus.sample;
        if (bus.sample[SAMPLE_W-1]) begin
            if (bus.sample == MOST_NEG) mag = MAG_MAX;
            else                        mag = -bus.sample;
        end
        full_scale = (mag >= MAG_MAX);
        level_in   = LVL_W'(vu_level(64'(mag), STEP, N_LEDS));
    end

    // Stage 1: capture the level of a strobed sample and mark it for stage 2.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            v1_q  <= 1'b0;
            lvl_q <= '0;
        end else begin
            v1_q <= bus.sample_valid;
            if (bus.sample_valid) lvl_q <= level_in;
        end
    end

    // Sticky clip flag; a new full-scale sample beats a simultaneous clear.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            clip_q <= 1'b0;
        end else if (bus.sample_valid && full_scale) begin
            clip_q <= 1'b1;
        end else if (bus.clip_clear) begin
            clip_q <= 1'b0;
        end
    end

    // Stage 2 next-state: attack beats the decay tick; peak holds, then
    // follows the bar's release ticks without dropping below the bar.
    always_comb begin
        attack     = (lvl_q > bar_q);
        decay_tick = !attack && (dcnt_q == DCNT_LAST);
        bar_n      = bar_q;
        dcnt_n     = dcnt_q;
        peak_n     = peak_q;
        hold_n     = hold_q;
        peak_dec   = peak_q - LVL_ONE;

        if (attack) begin
            bar_n  = lvl_q;
            dcnt_n = '0;
        end else if (decay_tick) begin
            if (bar_q != '0) bar_n = bar_q - LVL_ONE;
            dcnt_n = '0;
        end else begin
            dcnt_n = dcnt_q + DCNT_ONE;
        end

        if (lvl_q >= peak_q) begin
            peak_n = lvl_q;
            hold_n = HOLD_LOAD;
        end else if (hold_q != '0) begin
            hold_n = hold_q - HOLD_ONE;
        end else if (decay_tick) begin
            peak_n = (peak_dec > bar_n) ? peak_dec : bar_n;
        end
    end

    // Stage 2 state only moves on the edge after a strobed sample.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            bar_q  <= '0;
            peak_q <= '0;
            hold_q <= '0;
            dcnt_q <= '0;
        end else if (v1_q) begin
            bar_q  <= bar_n;
            peak_q <= peak_n;
            hold_q <= hold_n;
            dcnt_q <= dcnt_n;
        end
    end

    assign bus.bar  = bar_q;
    assign bus.peak = peak_q;
    assign bus.clip = clip_q;

endmodule

// File: rtl/vu_meter.sv
// Multi-channel VU meter: one vu_channel per input channel, then a
// registered display stage that renders the selected channel as bar or dot
// with the held peak segment always lit.
module vu_meter
    import vu_meter_pkg::*;
#(
    parameter int SAMPLE_W      = DEF_SAMPLE_W,
    parameter int N_LEDS        = DEF_N_LEDS,
    parameter int STEP          = DEF_STEP,
    parameter int CHANNELS      = DEF_CHANNELS,
    parameter int HOLD_SAMPLES  = DEF_HOLD_SAMPLES,
    parameter int DECAY_SAMPLES = DEF_DECAY_SAMPLES
) (
    input  logic                                            clock,
    input  logic                                            resetn,
    input  logic                                            sample_valid,
    input  logic [CHANNELS*SAMPLE_W-1:0]                    samples,
    input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] chan_sel,
    input  logic                                            dot_mode,
    input  logic                                            clip_clear,
    output logic [N_LEDS-1:0]                               LEDR,
    output logic [CHANNELS-1:0]                             clip
);

    localparam int LVL_W = $clog2(N_LEDS + 1);

    logic [LVL_W-1:0]  bars  [CHANNELS];
    logic [LVL_W-1:0]  peaks [CHANNELS];
    logic [LVL_W-1:0]  sel_bar;
    logic [LVL_W-1:0]  sel_peak;
    logic [LVL_W-1:0]  seg;
    logic [N_LEDS-1:0] led_next;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        vu_meter_if #(.SAMPLE_W(SAMPLE_W), .LVL_W(LVL_W)) ch_bus ();

        assign ch_bus.sample_valid = sample_valid;
        assign ch_bus.sample       = samples[g*SAMPLE_W +: SAMPLE_W];
        assign ch_bus.clip_clear   = clip_clear;

        vu_channel #(
            .SAMPLE_W      (SAMPLE_W),
            .N_LEDS        (N_LEDS),
            .STEP          (STEP),
            .HOLD_SAMPLES  (HOLD_SAMPLES),
            .DECAY_SAMPLES (DECAY_SAMPLES),
            .LVL_W         (LVL_W)
        ) u_chan (
            .clock  (clock),
            .resetn (resetn),
            .bus    (ch_bus)
        );

        assign bars[g]  = ch_bus.bar;
        assign peaks[g] = ch_bus.peak;
        assign clip[g]  = ch_bus.clip;
    end

    // Channel select; out-of-range selections fall back to channel 0.
    always_comb begin
        sel_bar  = bars[0];
        sel_peak = peaks[0];
        for (int c = 1; c < CHANNELS; c++) begin
            if (int'(chan_sel) == c) begin
                sel_bar  = bars[c];
                sel_peak = peaks[c];
            end
        end
    end

    // Segment i+1 is lit by the bar (all up to bar, or only bar in dot mode)
    // or by the peak marker.
    always_comb begin
        led_next = '0;
        seg      = '0;
        for (int i = 0; i < N_LEDS; i++) begin
            seg = LVL_W'(i + 1);
            if (dot_mode) led_next[i] = (sel_bar == seg);
            else          led_next[i] = (sel_bar >= seg);
            if (sel_peak == seg) led_next[i] = 1'b1;
        end
    end

    // Display register refreshes every cycle so select/mode changes show next edge.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) LEDR <= '0;
        else         LEDR <= led_next;
    end

endmodule
